// File: rtl/simple_tester.sv
// simple_tester: built-in tester that drives LFSR stimulus into a small
// AND-with-feedback DUT, checks its output against a reference model and
// counts mismatches.
// Optional feature: define SIMPLE_TESTER_STOP_ON_ERR_EN to end a test at the
// first mismatch instead of running all NUM_VECTORS vectors.
module simple_tester #(
    parameter int         NUM_VECTORS = 64,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         ERR_W       = 8
) (
    input  logic             iccad_clk,
    input  logic             iccad_rst,
    input  logic             start,
    output logic             inp1,
    output logic             inp2,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      vec_count
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0]      LAST_VEC = 16'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t     state;
    state_t     state_next;
    logic [7:0] lfsr;
    logic       model_q;
    logic       exp_bit;
    logic       mismatch;
    logic       last_vec;
    logic       stop_now;

    // Fibonacci step for x^8+x^6+x^5+x^4+1: shift left, feedback from taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // Reference response for the vector on inp1/inp2 right now, and the end-of-run decision.
    always_comb begin
        exp_bit  = inp1 & inp2 & ~model_q;
        mismatch = (state == RUN) && (dut_out != exp_bit);
        last_vec = (vec_count == LAST_VEC);
`ifdef SIMPLE_TESTER_STOP_ON_ERR_EN
        stop_now = last_vec || mismatch;
`else
        stop_now = last_vec;
`endif
    end

    // State register.
    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the state-decoded status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                busy       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (stop_now) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = INIT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stimulus generation, response checking and counters.
    always_ff @(posedge iccad_clk or posedge iccad_rst) begin
        if (iccad_rst) begin
            inp1      <= 1'b0;
            inp2      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            model_q   <= 1'b0;
            lfsr      <= SEED;
        end else begin
            case (state)
                IDLE, DONE: begin
                    inp1 <= 1'b0;
                    inp2 <= 1'b0;
                    if (start) begin
                        pass      <= 1'b0;
                        err_count <= '0;
                        vec_count <= '0;
                        lfsr      <= SEED;
                    end
                end
                INIT: begin
                    model_q <= 1'b0;
                    inp1    <= lfsr[0];
                    inp2    <= lfsr[1];
                    lfsr    <= lfsr_next(lfsr);
                end
                RUN: begin
                    vec_count <= vec_count + 16'd1;
                    model_q   <= exp_bit;
                    if (mismatch && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (stop_now) begin
                        inp1 <= 1'b0;
                        inp2 <= 1'b0;
                        pass <= (err_count == '0) && !mismatch;
                    end else begin
                        inp1 <= lfsr[0];
                        inp2 <= lfsr[1];
                        lfsr <= lfsr_next(lfsr);
                    end
                end
                default: begin
                    inp1 <= 1'b0;
                    inp2 <= 1'b0;
                end
            endcase
        end
    end

endmodule
